gas_id_bnn1_bnnparw: RTL and testbench

- Fully parallel two-layer binarized neural network classifier for the gas-identification dataset.
- Takes one 128-feature vector of 4-bit unsigned features and produces a class index (0..5).
- All weights are compile-time parameters; every neuron is evaluated in parallel in one combinational datapath.
- The result is registered; sits downstream of feature quantization and upstream of class-consuming logic.

---
 rtl/gas_id_bnn1_bnnparw_pkg.sv | 28 ++
 rtl/gas_id_bnn1_bnnparw_neuron.sv | 33 +++
 rtl/gas_id_bnn1_bnnparw.sv | 74 +++++++
 tb/tb_gas_id_bnn1_bnnparw.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gas_id_bnn1_bnnparw_pkg.sv
// Shared defaults, derived widths and the argmax tie rule for the gas-ID
// binarized classifier.
package gas_id_bnn1_bnnparw_pkg;

  localparam int DEF_FEAT_CNT   = 128;
  localparam int DEF_FEAT_BITS  = 4;
  localparam int DEF_HIDDEN_CNT = 40;
  localparam int DEF_CLASS_CNT  = 6;

  // Signed accumulator width that holds +/- feat_cnt * (2^feat_bits - 1)
  // without overflow: magnitude bits plus one sign bit.
  function automatic int acc_width(input int feat_cnt, input int feat_bits);
    return $clog2(feat_cnt * ((1 << feat_bits) - 1) + 1) + 1;
  endfunction

  localparam int ACC_W   = acc_width(DEF_FEAT_CNT, DEF_FEAT_BITS);  // 12
  localparam int SCORE_W = $clog2(DEF_HIDDEN_CNT + 1);              // 6
  localparam int IDX_W   = $clog2(DEF_CLASS_CNT);                   // 3

  // Which class wins when two scores are equal.
  typedef enum logic {
    TIE_LOWEST,
    TIE_HIGHEST
  } tie_rule_e;

  localparam tie_rule_e ARGMAX_TIE = TIE_LOWEST;

endpackage

// File: rtl/gas_id_bnn1_bnnparw_neuron.sv
// bnn_neuron_sum: one binary hidden neuron. Adds or subtracts each unsigned
// feature according to its +1/-1 weight and outputs the sign (zero -> 1).
module bnn_neuron_sum
  import gas_id_bnn1_bnnparw_pkg::*;
#(
  parameter int                  FEAT_CNT  = DEF_FEAT_CNT,
  parameter int                  FEAT_BITS = DEF_FEAT_BITS,
  parameter int                  ACC_BITS  = ACC_W,
  parameter logic [FEAT_CNT-1:0] WEIGHTS   = '0
) (
  input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
  output logic                          h
);

  logic signed [ACC_BITS-1:0] acc;
  logic signed [ACC_BITS-1:0] term;

  // Signed weighted sum of all features.
  always_comb begin
    // NOTE: every variable gets a default before the loop and is written with
    // blocking assignments, so this stays pure combinational logic (no latch).
    acc  = '0;
    term = '0;
    for (int i = 0; i < FEAT_CNT; i++) begin
      term = ACC_BITS'(features[i*FEAT_BITS +: FEAT_BITS]);
      if (WEIGHTS[i]) acc = acc + term;
      else            acc = acc - term;
    end
  end

  assign h = ~acc[ACC_BITS-1];

endmodule

// File: rtl/gas_id_bnn1_bnnparw.sv
// Fully parallel two-layer BNN classifier: 40 sign neurons, XNOR-popcount
// class scores, lowest-index argmax, registered class index.
module gas_id_bnn1_bnnparw
  import gas_id_bnn1_bnnparw_pkg::*;
#(
  parameter int                                FEAT_CNT   = DEF_FEAT_CNT,
  parameter int                                FEAT_BITS  = DEF_FEAT_BITS,
  parameter int                                HIDDEN_CNT = DEF_HIDDEN_CNT,
  parameter int                                CLASS_CNT  = DEF_CLASS_CNT,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]    W1         = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0]   W2         = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FEAT_CNT*FEAT_BITS-1:0]     features,
  output logic [$clog2(CLASS_CNT)-1:0]      prediction
);

  localparam int ACC_BITS   = acc_width(FEAT_CNT, FEAT_BITS);
  localparam int SCORE_BITS = $clog2(HIDDEN_CNT + 1);
  localparam int IDX_BITS   = $clog2(CLASS_CNT);

  logic [HIDDEN_CNT-1:0] hidden;
  logic [SCORE_BITS-1:0] score [CLASS_CNT];
  logic [SCORE_BITS-1:0] best_score;
  logic [IDX_BITS-1:0]   prediction_d;
  logic [IDX_BITS-1:0]   prediction_q;

  // Layer 1: one sign neuron per hidden unit, each with its own weight row.
  for (genvar j = 0; j < HIDDEN_CNT; j++) begin : g_hidden
    bnn_neuron_sum #(
      .FEAT_CNT (FEAT_CNT),
      .FEAT_BITS(FEAT_BITS),
      .ACC_BITS (ACC_BITS),
      .WEIGHTS  (W1[j*FEAT_CNT +: FEAT_CNT])
    ) u_neuron (
      .features(features),
      .h       (hidden[j])
    );
  end

  // Layer 2: score of each class is the number of hidden bits agreeing with
  // its weight row.
  always_comb begin
    for (int c = 0; c < CLASS_CNT; c++) begin
      score[c] = SCORE_BITS'($countones(~(hidden ^ W2[c*HIDDEN_CNT +: HIDDEN_CNT])));
    end
  end

  // Argmax scanning upward; only a strictly larger score displaces the
  // current winner, so ties keep the lower class.
  always_comb begin
    best_score   = score[0];
    prediction_d = '0;
    for (int c = 1; c < CLASS_CNT; c++) begin
      if ((score[c] > best_score) ||
          ((ARGMAX_TIE == TIE_HIGHEST) && (score[c] == best_score))) begin
        best_score   = score[c];
        prediction_d = IDX_BITS'(c);
      end
    end
  end

  // Result register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    if (rst) prediction_q <= '0;
    else     prediction_q <= prediction_d;
  end

  assign prediction = prediction_q;

endmodule

// File: tb/tb_gas_id_bnn1_bnnparw.sv
// Self-checking bench: several weight configurations instantiated side by
// side, a directed vector table, hand-written latency/reset sequences and a
// randomized run against a behavioural model of the network.
module tb_gas_id_bnn1_bnnparw;
  import gas_id_bnn1_bnnparw_pkg::*;

  localparam int FC      = DEF_FEAT_CNT;
  localparam int FB      = DEF_FEAT_BITS;
  localparam int HC      = DEF_HIDDEN_CNT;
  localparam int CC      = DEF_CLASS_CNT;
  localparam int W1_BITS = HC * FC;
  localparam int W2_BITS = CC * HC;
  localparam int FEAT_W  = FC * FB;

  // Pseudo-random weights: a 37-bit pattern repeated, so rows (length 128/40)
  // differ from one another.
  localparam logic [5142:0] W1_RAW = {139{37'h1A5B3C7D1}};
  localparam logic [258:0]  W2_RAW = {7{37'h0C3E5F1B7}};
  localparam logic [W1_BITS-1:0] W1_R    = W1_RAW[W1_BITS-1:0];
  localparam logic [W2_BITS-1:0] W2_R    = W2_RAW[W2_BITS-1:0];
  localparam logic [W1_BITS-1:0] W1_ONES = '1;
  localparam logic [W1_BITS-1:0] W1_ZERO = '0;
  localparam logic [W1_BITS-1:0] W1_ROW0 = {{(W1_BITS-FC){1'b0}}, {FC{1'b1}}};
  localparam logic [W2_BITS-1:0] W2_A    = {{(2*HC){1'b0}}, {HC{1'b1}}, {(3*HC){1'b0}}};
  localparam logic [W2_BITS-1:0] W2_B    = {{HC{1'b0}}, {(5*HC){1'b1}}};
  localparam logic [HC-1:0]      W2_ROWT = W2_R[HC-1:0];
  localparam logic [W2_BITS-1:0] W2_TIE  = {CC{W2_ROWT}};
  localparam logic [W2_BITS-1:0] W2_C    = {{((CC-2)*HC-1){1'b0}}, 1'b1, {(2*HC){1'b0}}};

  logic              clk = 1'b0;
  logic              rst;
  logic [FEAT_W-1:0] features;
  logic [IDX_W-1:0]  pred_r, pred_a, pred_b, pred_t, pred_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gas_id_bnn1_bnnparw #(.W1(W1_R), .W2(W2_R)) u_rand (
    .clk(clk), .rst(rst), .features(features), .prediction(pred_r));
  gas_id_bnn1_bnnparw #(.W1(W1_ONES), .W2(W2_A)) u_a (
    .clk(clk), .rst(rst), .features(features), .prediction(pred_a));
  gas_id_bnn1_bnnparw #(.W1(W1_ZERO), .W2(W2_B)) u_b (
    .clk(clk), .rst(rst), .features(features), .prediction(pred_b));
  gas_id_bnn1_bnnparw #(.W1(W1_R), .W2(W2_TIE)) u_tie (
    .clk(clk), .rst(rst), .features(features), .prediction(pred_t));
  gas_id_bnn1_bnnparw #(.W1(W1_ROW0), .W2(W2_C)) u_acc (
    .clk(clk), .rst(rst), .features(features), .prediction(pred_c));

  typedef struct {
    logic              rst;
    logic [FEAT_W-1:0] feat;
    logic [IDX_W-1:0]  exp_a;
    logic [IDX_W-1:0]  exp_b;
    logic [IDX_W-1:0]  exp_c;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [IDX_W-1:0] act,
                       input logic [IDX_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural network: integer sums, sign, agreement counts, first maximum.
  function automatic logic [IDX_W-1:0] golden(input logic [W1_BITS-1:0] w1,
                                               input logic [W2_BITS-1:0] w2,
                                               input logic [FEAT_W-1:0]  f);
    int s, x, score, best, best_c;
    bit h [HC];
    for (int j = 0; j < HC; j++) begin
      s = 0;
      for (int i = 0; i < FC; i++) begin
        x = int'(f[i*FB +: FB]);
        if (w1[j*FC+i]) s += x;
        else            s -= x;
      end
      h[j] = (s >= 0);
    end
    best   = -1;
    best_c = 0;
    for (int c = 0; c < CC; c++) begin
      score = 0;
      for (int j = 0; j < HC; j++) if (h[j] == w2[c*HC+j]) score++;
      if (score > best) begin
        best   = score;
        best_c = c;
      end
    end
    return IDX_W'(best_c);
  endfunction

  function automatic logic [FEAT_W-1:0] rand_feat();
    logic [FEAT_W-1:0] v;
    v = '0;
    for (int k = 0; k < FEAT_W/32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic vec_t mk(input logic r, input logic [FEAT_W-1:0] f,
                              input int a, input int b, input int c);
    vec_t v;
    v.rst   = r;
    v.feat  = f;
    v.exp_a = IDX_W'(a);
    v.exp_b = IDX_W'(b);
    v.exp_c = IDX_W'(c);
    return v;
  endfunction

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [IDX_W-1:0] exp_r;

    // Directed vectors; the tie instance must always report class 0.
    vecs[0] = mk(1'b1, {FC{4'hF}},    0, 0, 0);
    vecs[1] = mk(1'b0, {FC{4'hF}},    3, 5, 2);  // s=-1920 / +1920 extremes
    vecs[2] = mk(1'b0, {FC{4'h0}},    3, 0, 2);  // s=0 -> h=1, rows 0-4 tie
    vecs[3] = mk(1'b0, {FC{4'h1}},    3, 5, 2);
    vecs[4] = mk(1'b1, {FC{4'hF}},    0, 0, 0);  // reset mid-stream
    vecs[5] = mk(1'b0, {64{8'h0F}},   3, 5, 2);
    vecs[6] = mk(1'b0, {64{8'hF0}},   3, 5, 2);

    // Reset held for three edges with random features.
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      features = rand_feat();
      edge_sample();
      check($sformatf("reset%0d_r", k), pred_r, '0);
      check($sformatf("reset%0d_a", k), pred_a, '0);
      check($sformatf("reset%0d_b", k), pred_b, '0);
      check($sformatf("reset%0d_c", k), pred_c, '0);
    end

    // Table-driven vectors.
    for (int k = 0; k < 7; k++) begin
      rst      = vecs[k].rst;
      features = vecs[k].feat;
      edge_sample();
      exp_r = vecs[k].rst ? '0 : golden(W1_R, W2_R, vecs[k].feat);
      check($sformatf("vec%0d_a", k), pred_a, vecs[k].exp_a);
      check($sformatf("vec%0d_b", k), pred_b, vecs[k].exp_b);
      check($sformatf("vec%0d_c", k), pred_c, vecs[k].exp_c);
      check($sformatf("vec%0d_tie", k), pred_t, '0);
      check($sformatf("vec%0d_r", k), pred_r, exp_r);
    end

    // Latency: output holds until the edge after the features change.
    rst      = 1'b0;
    features = {FC{4'hF}};
    edge_sample();
    check("lat_first_b", pred_b, 3'd5);
    features = {FC{4'h0}};
    #2;
    check("lat_hold_b", pred_b, 3'd5);
    edge_sample();
    check("lat_next_b", pred_b, 3'd0);

    // Reset mid-stream, then first valid result on first edge with rst low.
    rst      = 1'b1;
    features = {FC{4'hF}};
    edge_sample();
    check("midrst_b", pred_b, 3'd0);
    check("midrst_a", pred_a, 3'd0);
    rst = 1'b0;
    edge_sample();
    check("postrst_b", pred_b, 3'd5);
    check("postrst_a", pred_a, 3'd3);

    // Randomized back-to-back stream with occasional reset pulses.
    for (int k = 0; k < 1000; k++) begin
      rst      = ($urandom_range(0, 49) == 0);
      features = rand_feat();
      edge_sample();
      if (rst) begin
        check($sformatf("rnd%0d_rst_r", k), pred_r, '0);
        check($sformatf("rnd%0d_rst_b", k), pred_b, '0);
      end else begin
        check($sformatf("rnd%0d_r", k), pred_r, golden(W1_R, W2_R, features));
        check($sformatf("rnd%0d_b", k), pred_b, golden(W1_ZERO, W2_B, features));
        check($sformatf("rnd%0d_c", k), pred_c, golden(W1_ROW0, W2_C, features));
        check($sformatf("rnd%0d_a", k), pred_a, 3'd3);
        check($sformatf("rnd%0d_tie", k), pred_t, 3'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
